// File: rtl/i2c_slave_fsm_if.sv
// ============================================================================
// Module      : i2c_slave_fsm_if
// Description : Bus pins and user byte handshake of the I2C slave engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_slave_fsm_if #(
  parameter int DATA_LEN = 8
);
  logic                scl_in;
  logic                sda_in;
  logic                sda_oe;
  logic [DATA_LEN-1:0] tx_data;
  logic                tx_req;
  logic [DATA_LEN-1:0] rx_data;
  logic                rx_valid;
  logic                addr_match;
  logic                busy;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, tx_req, rx_data, rx_valid, addr_match, busy
  );

  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, tx_req, rx_data, rx_valid, addr_match, busy
  );
endinterface

`default_nettype wire

// File: rtl/i2c_slave_fsm.sv
// ============================================================================
// Module      : i2c_slave_fsm
// Description : clk-oversampled I2C slave; address match, byte RX and TX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave_fsm #(
  parameter int                  ADDR_LEN   = 7,
  parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = 7'h50,
  parameter int                  DATA_LEN   = 8
) (
  input  wire                  clk,
  input  wire                  rst_n,
  i2c_slave_fsm_if.slave       bus
);

  localparam int SH_W  = (ADDR_LEN + 1 > DATA_LEN) ? ADDR_LEN + 1 : DATA_LEN;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(ADDR_LEN + 1);
  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(DATA_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    RX        = 3'd3,
    RX_ACK    = 3'd4,
    TX        = 3'd5,
    TX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  state_t              r_state,   w_state_n;
  logic [CNT_W-1:0]    r_cnt,     w_cnt_n;
  logic [SH_W-1:0]     r_shift,   w_shift_n;
  logic [DATA_LEN-1:0] r_tx_sh,   w_tx_sh_n;
  logic                r_rw,      w_rw_n;
  logic [DATA_LEN-1:0] r_rx_data, w_rx_data_n;
  logic                r_sda_oe,  w_sda_oe_n;
  logic                r_busy,    w_busy_n;
  logic                r_tx_req,  w_tx_req_n;
  logic                r_rx_vld,  w_rx_vld_n;
  logic                r_match,   w_match_n;

  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  // Two flops for metastability, the third is the previous-sample copy for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= bus.scl_in; r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= bus.sda_in; r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '1;
      r_tx_sh   <= '1;
      r_rw      <= 1'b1;
      r_rx_data <= '0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_req  <= 1'b0;
      r_rx_vld  <= 1'b0;
      r_match   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_shift   <= w_shift_n;
      r_tx_sh   <= w_tx_sh_n;
      r_rw      <= w_rw_n;
      r_rx_data <= w_rx_data_n;
      r_sda_oe  <= w_sda_oe_n;
      r_busy    <= w_busy_n;
      r_tx_req  <= w_tx_req_n;
      r_rx_vld  <= w_rx_vld_n;
      r_match   <= w_match_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_shift_n   = r_shift;
    w_tx_sh_n   = r_tx_sh;
    w_rw_n      = r_rw;
    w_rx_data_n = r_rx_data;
    w_sda_oe_n  = r_sda_oe;
    w_busy_n    = r_busy;
    w_tx_req_n  = 1'b0;
    w_rx_vld_n  = 1'b0;
    w_match_n   = 1'b0;

    if (w_start) begin
      w_state_n  = ADDR;
      w_cnt_n    = '0;
      w_shift_n  = '1;
      w_sda_oe_n = 1'b0;
      w_busy_n   = 1'b0;
    end else if (w_stop) begin
      w_state_n  = IDLE;
      w_sda_oe_n = 1'b0;
      w_busy_n   = 1'b0;
    end else begin
      case (r_state)
        ADDR: begin
          if (w_scl_rise) begin
            w_shift_n = {r_shift[SH_W-2:0], r_sda_s2};
            w_cnt_n   = r_cnt + CNT_ONE;
          end else if (w_scl_fall && r_cnt == ADDR_BITS) begin
            w_rw_n = r_shift[0];
            if (r_shift[ADDR_LEN:1] == SLAVE_ADDR) begin
              w_state_n  = ADDR_ACK;
              w_sda_oe_n = 1'b1;
              w_match_n  = 1'b1;
              w_busy_n   = 1'b1;
            end else begin
              w_state_n  = WAIT_STOP;
              w_sda_oe_n = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (w_scl_fall) begin
            if (r_rw) begin
              w_state_n  = TX;
              w_tx_sh_n  = bus.tx_data;
              w_tx_req_n = 1'b1;
              w_sda_oe_n = ~bus.tx_data[DATA_LEN-1];
            end else begin
              w_state_n  = RX;
              w_sda_oe_n = 1'b0;
            end
          end
        end
        RX: begin
          if (w_scl_rise) begin
            w_shift_n = {r_shift[SH_W-2:0], r_sda_s2};
            w_cnt_n   = r_cnt + CNT_ONE;
          end else if (w_scl_fall && r_cnt == DATA_BITS) begin
            w_state_n   = RX_ACK;
            w_rx_data_n = r_shift[DATA_LEN-1:0];
            w_rx_vld_n  = 1'b1;
            w_sda_oe_n  = 1'b1;
          end
        end
        RX_ACK: begin
          if (w_scl_fall) begin
            w_state_n  = RX;
            w_sda_oe_n = 1'b0;
          end
        end
        TX: begin
          // The MSB is already on the wire; each fall shifts the next bit up.
          if (w_scl_rise) begin
            w_cnt_n = r_cnt + CNT_ONE;
          end else if (w_scl_fall) begin
            if (r_cnt == DATA_BITS) begin
              w_state_n  = TX_ACK;
              w_sda_oe_n = 1'b0;
            end else begin
              w_tx_sh_n  = {r_tx_sh[DATA_LEN-2:0], 1'b1};
              w_sda_oe_n = ~r_tx_sh[DATA_LEN-2];
            end
          end
        end
        TX_ACK: begin
          // r_cnt doubles as the "master acknowledged" flag here.
          if (w_scl_rise) begin
            if (r_sda_s2) w_state_n = WAIT_STOP;
            else          w_cnt_n   = CNT_ONE;
          end else if (w_scl_fall && r_cnt == CNT_ONE) begin
            w_state_n  = TX;
            w_tx_sh_n  = bus.tx_data;
            w_tx_req_n = 1'b1;
            w_sda_oe_n = ~bus.tx_data[DATA_LEN-1];
          end
        end
        WAIT_STOP: w_sda_oe_n = 1'b0;
        default:   w_state_n  = IDLE;
      endcase
    end

    if (w_state_n != r_state) w_cnt_n = '0;
  end

  assign bus.sda_oe     = r_sda_oe;
  assign bus.tx_req     = r_tx_req;
  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_vld;
  assign bus.addr_match = r_match;
  assign bus.busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_fsm.sv
// ============================================================================
// Module      : tb_i2c_slave_fsm
// Description : Directed bus-level bench for i2c_slave_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_slave_fsm;

  logic       clk;
  logic       rst_n;
  logic       r_scl_m;
  logic       r_sda_m;
  logic [7:0] r_tx_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txreq  = 0;
  int n_rxvld  = 0;
  int n_match  = 0;
  int n_oe     = 0;

  i2c_slave_fsm_if #(.DATA_LEN(8)) u_if ();

  assign u_if.scl_in  = r_scl_m;
  assign u_if.sda_in  = r_sda_m & ~u_if.sda_oe;
  assign u_if.tx_data = r_tx_data;

  i2c_slave_fsm #(
    .ADDR_LEN   (7),
    .SLAVE_ADDR (7'h50),
    .DATA_LEN   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (u_if.tx_req)     n_txreq <= n_txreq + 1;
    if (u_if.rx_valid)   n_rxvld <= n_rxvld + 1;
    if (u_if.addr_match) n_match <= n_match + 1;
    if (u_if.sda_oe)     n_oe    <= n_oe + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (8) @(negedge clk);
  endtask

  task automatic i2c_start();
    r_sda_m = 1'b1; r_scl_m = 1'b1; wait_q();
    r_sda_m = 1'b0; wait_q();
    r_scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_rstart();
    r_sda_m = 1'b1; wait_q();
    r_scl_m = 1'b1; wait_q();
    r_sda_m = 1'b0; wait_q();
    r_scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    r_sda_m = 1'b0; wait_q();
    r_scl_m = 1'b1; wait_q();
    r_sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    r_sda_m = b; wait_q();
    r_scl_m = 1'b1; wait_q(); wait_q();
    r_scl_m = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    r_sda_m = 1'b1; wait_q();
    r_scl_m = 1'b1; wait_q();
    b = u_if.sda_in; wait_q();
    r_scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  initial begin : main
    logic       ack;
    logic [7:0] d;
    int         b_tx, b_rx, b_m, b_oe;

    rst_n = 1'b0; r_scl_m = 1'b1; r_sda_m = 1'b1; r_tx_data = 8'h00;
    repeat (4) @(negedge clk);
    chk("rst_sda_oe",  {31'd0, u_if.sda_oe}, 32'd0);
    chk("rst_busy",    {31'd0, u_if.busy}, 32'd0);
    chk("rst_rx_data", {24'd0, u_if.rx_data}, 32'h00);
    chk("rst_pulses",  {29'd0, u_if.tx_req, u_if.rx_valid, u_if.addr_match}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // write 0xA0 then 0x3C
    b_rx = n_rxvld; b_m = n_match;
    i2c_start();
    write_byte(8'hA0, ack);
    chk("wr_addr_ack", {31'd0, ack}, 32'd0);
    chk("wr_match_cnt", n_match - b_m, 32'd1);
    chk("wr_busy", {31'd0, u_if.busy}, 32'd1);
    write_byte(8'h3C, ack);
    chk("wr_data_ack", {31'd0, ack}, 32'd0);
    chk("wr_rx_data", {24'd0, u_if.rx_data}, 32'h3C);
    chk("wr_rxvld_cnt", n_rxvld - b_rx, 32'd1);
    i2c_stop();
    chk("wr_busy_stop", {31'd0, u_if.busy}, 32'd0);
    chk("wr_oe_stop", {31'd0, u_if.sda_oe}, 32'd0);

    // read 0xC5 (ACK) then 0x12 (NACK)
    b_tx = n_txreq;
    r_tx_data = 8'hC5;
    i2c_start();
    write_byte(8'hA1, ack);
    chk("rd_addr_ack", {31'd0, ack}, 32'd0);
    r_tx_data = 8'h12;
    read_byte(d, 1'b0);
    chk("rd_byte0", {24'd0, d}, 32'hC5);
    read_byte(d, 1'b1);
    chk("rd_byte1", {24'd0, d}, 32'h12);
    chk("rd_txreq_cnt", n_txreq - b_tx, 32'd2);
    b_oe = n_oe;
    repeat (4) write_bit(1'b0);
    chk("rd_wait_stop_oe", n_oe - b_oe, 32'd0);
    chk("rd_busy_wait", {31'd0, u_if.busy}, 32'd1);
    i2c_stop();
    chk("rd_busy_stop", {31'd0, u_if.busy}, 32'd0);

    // wrong address 0x51
    b_m = n_match; b_oe = n_oe;
    i2c_start();
    write_byte(8'hA2, ack);
    chk("na_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h00, ack);
    chk("na_data_ack", {31'd0, ack}, 32'd1);
    chk("na_match_cnt", n_match - b_m, 32'd0);
    chk("na_oe_cnt", n_oe - b_oe, 32'd0);
    i2c_stop();

    // write 0x77, repeated START, read
    b_m = n_match;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h77, ack);
    chk("rs_data_ack", {31'd0, ack}, 32'd0);
    r_tx_data = 8'h9B;
    i2c_rstart();
    write_byte(8'hA1, ack);
    chk("rs_addr_ack", {31'd0, ack}, 32'd0);
    chk("rs_rx_data", {24'd0, u_if.rx_data}, 32'h77);
    chk("rs_match_cnt", n_match - b_m, 32'd2);
    chk("rs_busy", {31'd0, u_if.busy}, 32'd1);
    read_byte(d, 1'b1);
    chk("rs_tx_byte", {24'd0, d}, 32'h9B);
    i2c_stop();

    // reset during RX_ACK
    i2c_start();
    write_byte(8'hA0, ack);
    for (int i = 7; i >= 0; i--) write_bit(i[0]);
    r_sda_m = 1'b1;
    chk("ra_oe_before", {31'd0, u_if.sda_oe}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_oe_async", {31'd0, u_if.sda_oe}, 32'd0);
    chk("ra_busy", {31'd0, u_if.busy}, 32'd0);
    chk("ra_rx_data", {24'd0, u_if.rx_data}, 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b_m = n_match; b_oe = n_oe;
    write_byte(8'hA0, ack);
    chk("ra_ignore_ack", {31'd0, ack}, 32'd1);
    chk("ra_ignore_match", n_match - b_m, 32'd0);
    chk("ra_ignore_oe", n_oe - b_oe, 32'd0);
    i2c_start();
    write_byte(8'hA0, ack);
    chk("ra_resume_ack", {31'd0, ack}, 32'd0);
    i2c_stop();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
